// File: rtl/stolen_alarm.sv
// Stolen-item alarm: qualifies a stolen flag over consecutive cycles for a
// stable item code, then latches an alarm with a blinking indicator until
// the operator acknowledges. Counts raised alarms and remembers the code of
// the most recent alarmed item.
module stolen_alarm #(
  parameter int unsigned QUAL_CYCLES = 4,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stolen,
  input  logic [2:0] upc,
  input  logic       ack,
  output logic       alarm,
  output logic       blink,
  output logic [3:0] event_count,
  output logic [2:0] last_upc
);

  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [3:0]    QUAL_LAST  = 4'(QUAL_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUAL,
    S_ALARM,
    S_CLEAR
  } state_t;

  state_t        r_state;
  logic [3:0]    r_qual_cnt;
  logic [BW-1:0] r_blink_cnt;
  logic [2:0]    r_candidate;
  logic [2:0]    r_last_upc;
  logic [3:0]    r_event_count;
  logic          r_alarm;
  logic          r_blink;

  logic          w_cand_match;
  logic          w_qual_done;
  logic [3:0]    w_event_next;

  // Qualification and bookkeeping helpers derived from current state/inputs
  always_comb begin
    w_cand_match = (upc == r_candidate);
    w_qual_done  = (r_qual_cnt == QUAL_LAST);
    w_event_next = (r_event_count == 4'hF) ? 4'hF : r_event_count + 4'd1;
  end

  // Moore FSM with registered outputs; every ALARM entry loads last_upc,
  // bumps the saturating event counter and restarts the blink phase
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_qual_cnt    <= '0;
      r_blink_cnt   <= '0;
      r_candidate   <= '0;
      r_last_upc    <= '0;
      r_event_count <= '0;
      r_alarm       <= 1'b0;
      r_blink       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_alarm <= 1'b0;
          r_blink <= 1'b0;
          if (stolen) begin
            r_candidate <= upc;
            if (QUAL_CYCLES == 1) begin
              // Single-cycle qualification: the captured code is the alarmed one
              r_state       <= S_ALARM;
              r_qual_cnt    <= '0;
              r_last_upc    <= upc;
              r_event_count <= w_event_next;
              r_alarm       <= 1'b1;
              r_blink       <= 1'b1;
              r_blink_cnt   <= '0;
            end else begin
              r_state    <= S_QUAL;
              r_qual_cnt <= 4'd1;
            end
          end
        end

        S_QUAL: begin
          r_alarm <= 1'b0;
          r_blink <= 1'b0;
          if (!stolen) begin
            r_state    <= S_IDLE;
            r_qual_cnt <= '0;
          end else if (!w_cand_match) begin
            // A different item restarts qualification from its first cycle
            r_candidate <= upc;
            r_qual_cnt  <= 4'd1;
          end else if (w_qual_done) begin
            r_state       <= S_ALARM;
            r_qual_cnt    <= '0;
            r_last_upc    <= r_candidate;
            r_event_count <= w_event_next;
            r_alarm       <= 1'b1;
            r_blink       <= 1'b1;
            r_blink_cnt   <= '0;
          end else begin
            r_qual_cnt <= r_qual_cnt + 4'd1;
          end
        end

        S_ALARM: begin
          if (ack) begin
            r_state     <= S_CLEAR;
            r_alarm     <= 1'b0;
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
          end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink     <= ~r_blink;
            r_blink_cnt <= '0;
          end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
          end
        end

        S_CLEAR: begin
          r_alarm <= 1'b0;
          r_blink <= 1'b0;
          // Wait for the item to be gone and ack released before re-arming
          if (!stolen && !ack) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign alarm       = r_alarm;
  assign blink       = r_blink;
  assign event_count = r_event_count;
  assign last_upc    = r_last_upc;

endmodule

// File: tb/tb_stolen_alarm.sv
// Directed bench for stolen_alarm with QUAL_CYCLES=4, BLINK_DIV=2.
module tb_stolen_alarm;

  typedef struct {
    logic       rst;
    logic       st;
    logic [2:0] upc;
    logic       ack;
    logic       ea;
    logic       eb;
    logic [3:0] ec;
    logic [2:0] el;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       stolen;
  logic [2:0] upc;
  logic       ack;
  logic       alarm;
  logic       blink;
  logic [3:0] event_count;
  logic [2:0] last_upc;

  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;
  vec_t vecs[$];
  vec_t sb[$];

  stolen_alarm #(
    .QUAL_CYCLES(4),
    .BLINK_DIV  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stolen     (stolen),
    .upc        (upc),
    .ack        (ack),
    .alarm      (alarm),
    .blink      (blink),
    .event_count(event_count),
    .last_upc   (last_upc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic void add(input logic r, input logic s, input logic [2:0] u,
                              input logic a, input logic ea, input logic eb,
                              input logic [3:0] ec, input logic [2:0] el);
    vec_t v;
    v.rst = r; v.st = s; v.upc = u; v.ack = a;
    v.ea = ea; v.eb = eb; v.ec = ec; v.el = el;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    reset  = v.rst;
    stolen = v.st;
    upc    = v.upc;
    ack    = v.ack;
    sb.push_back(v);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s#%0d: scoreboard empty", tag, vec_idx);
    end else begin
      e = sb.pop_front();
      if (alarm !== e.ea || blink !== e.eb || event_count !== e.ec || last_upc !== e.el) begin
        errors++;
        $display("FAIL %s#%0d: got alarm=%b blink=%b count=%0d last=%b, expected alarm=%b blink=%b count=%0d last=%b",
                 tag, vec_idx, alarm, blink, event_count, last_upc, e.ea, e.eb, e.ec, e.el);
      end
    end
    vec_idx++;
  endtask

  initial begin
    vec_t v;
    int   cnt;
    logic [2:0] lu;

    reset = 1'b1; stolen = 1'b0; upc = 3'b000; ack = 1'b0;

    // reset, including reset dominating active inputs
    add(1,0,3'd0,0, 0,0,4'd0,3'd0);
    add(1,1,3'd7,1, 0,0,4'd0,3'd0);
    // four qualified edges of 101 raise the alarm
    for (int i = 0; i < 3; i++) add(0,1,3'd5,0, 0,0,4'd0,3'd0);
    add(0,1,3'd5,0, 1,1,4'd1,3'd5);
    // alarm latched with stolen low; blink runs 1,1,0,0,1,1
    add(0,0,3'd0,0, 1,1,4'd1,3'd5);
    add(0,0,3'd0,0, 1,0,4'd1,3'd5);
    add(0,0,3'd0,0, 1,0,4'd1,3'd5);
    add(0,0,3'd0,0, 1,1,4'd1,3'd5);
    add(0,0,3'd0,0, 1,1,4'd1,3'd5);
    // ack with stolen high -> CLEAR; CLEAR holds while stolen stays high
    add(0,1,3'd0,1, 0,0,4'd1,3'd5);
    for (int i = 0; i < 5; i++) add(0,1,3'd5,0, 0,0,4'd1,3'd5);
    add(0,0,3'd0,1, 0,0,4'd1,3'd5);
    add(0,0,3'd0,0, 0,0,4'd1,3'd5);
    // three highs then low abort; a fresh alarm needs four more highs
    for (int i = 0; i < 3; i++) add(0,1,3'd2,0, 0,0,4'd1,3'd5);
    add(0,0,3'd2,0, 0,0,4'd1,3'd5);
    for (int i = 0; i < 3; i++) add(0,1,3'd2,0, 0,0,4'd1,3'd5);
    add(0,1,3'd2,0, 1,1,4'd2,3'd2);
    add(0,1,3'd0,1, 0,0,4'd2,3'd2);
    add(0,0,3'd0,0, 0,0,4'd2,3'd2);
    add(0,0,3'd0,1, 0,0,4'd2,3'd2);
    // code change mid-qualification restarts count; ack ignored in IDLE/QUAL
    add(0,1,3'd5,1, 0,0,4'd2,3'd2);
    add(0,1,3'd5,0, 0,0,4'd2,3'd2);
    add(0,1,3'd3,1, 0,0,4'd2,3'd2);
    add(0,1,3'd3,0, 0,0,4'd2,3'd2);
    add(0,1,3'd3,0, 0,0,4'd2,3'd2);
    add(0,1,3'd3,0, 1,1,4'd3,3'd3);
    // reset during ALARM with count 3
    add(0,0,3'd0,0, 1,1,4'd3,3'd3);
    add(1,1,3'd3,0, 0,0,4'd0,3'd0);
    add(0,0,3'd0,0, 0,0,4'd0,3'd0);
    // reset mid-QUAL discards partial qualification
    add(0,1,3'd7,0, 0,0,4'd0,3'd0);
    add(0,1,3'd7,0, 0,0,4'd0,3'd0);
    add(1,1,3'd7,0, 0,0,4'd0,3'd0);
    for (int i = 0; i < 3; i++) add(0,1,3'd7,0, 0,0,4'd0,3'd0);
    add(0,1,3'd7,0, 1,1,4'd1,3'd7);

    foreach (vecs[i]) step(vecs[i], "vec");

    // saturation: 16 more alarm/ack rounds from count 1 must stop at 15
    cnt = 1;
    lu  = 3'd7;
    for (int i = 1; i <= 16; i++) begin
      v.rst = 0; v.st = 1; v.upc = 3'd0; v.ack = 1;
      v.ea = 0; v.eb = 0; v.ec = 4'(cnt); v.el = lu;
      step(v, "sat_clr");
      v.st = 0; v.ack = 0;
      step(v, "sat_idle");
      lu = 3'(i);
      v.st = 1; v.upc = lu;
      for (int k = 0; k < 3; k++) step(v, "sat_qual");
      cnt = (cnt < 15) ? cnt + 1 : 15;
      v.ea = 1; v.eb = 1; v.ec = 4'(cnt); v.el = lu;
      step(v, "sat_alarm");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
